// File: rtl/btn_seq_pkg.sv
// Shared types and constants for the button sequence driver.
package btn_seq_pkg;

  // Debouncer characteristics the key timing has to satisfy.
  localparam int unsigned DEBOUNCE_DEPTH = 10;
  localparam int unsigned RELEASE_HOLD   = 50000;

  // Shortest press the debouncer registers, and shortest release it needs
  // before it sees a clean new edge.
  localparam int unsigned PRESS_MIN = DEBOUNCE_DEPTH;
  localparam int unsigned GAP_MIN   = RELEASE_HOLD + DEBOUNCE_DEPTH;

  localparam int unsigned PRESS_CYCLES_DEF = 16;
  localparam int unsigned GAP_CYCLES_DEF   = 50020;
  localparam int unsigned CNT_W_DEF        = 16;

  typedef enum logic [2:0] {
    IDLE,
    BIT_PRESS,
    BIT_GAP,
    START_PRESS,
    START_GAP,
    ABORT_PRESS,
    ABORT_GAP
  } seq_state_t;

  typedef struct packed {
    logic one_n;
    logic zero_n;
    logic start_n;
    logic reset_btn_n;
  } lines_t;

  // Button line levels for a given state; at most one line is ever low.
  function automatic lines_t lines_for(seq_state_t st, logic bit_val);
    lines_t l;
    l = '1;
    case (st)
      BIT_PRESS: begin
        if (bit_val) l.one_n  = 1'b0;
        else         l.zero_n = 1'b0;
      end
      START_PRESS: l.start_n     = 1'b0;
      ABORT_PRESS: l.reset_btn_n = 1'b0;
      default:     l = '1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/button_seq_driver_if.sv
// Code-word handshake and button line bundle between the game controller
// (master) and the sequence driver (slave).
interface button_seq_driver_if;
  logic       in_valid;
  logic [7:0] in_code;
  logic       in_ready;
  logic       abort;
  logic       one_n;
  logic       zero_n;
  logic       start_n;
  logic       reset_btn_n;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_code, abort,
    input  in_ready, one_n, zero_n, start_n, reset_btn_n, busy, done
  );

  modport slave (
    input  in_valid, in_code, abort,
    output in_ready, one_n, zero_n, start_n, reset_btn_n, busy, done
  );
endinterface

// File: rtl/btn_phase_timer.sv
// Phase timer shared by all sequence states: counts 0..limit, restarts on load.
module btn_phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Count register: cleared on reset or load, advances while enabled.
  always_ff @(posedge clk) begin
    if (reset || load) count <= '0;
    else if (en)       count <= count + CNT_W'(1);
  end

  assign tc = (count == limit);

endmodule

// File: rtl/button_seq_driver.sv
// Keys an 8-bit code word (or a reset sequence on abort) onto the four
// active-low button lines of the code-entry debouncer.
module button_seq_driver
  import btn_seq_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = PRESS_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  button_seq_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] PRESS_LIM = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       state, state_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       code, code_nx;
  logic             post_abort, post_nx;
  logic             done_nx;
  logic [CNT_W-1:0] limit;
  logic             load;
  logic             tc;
  lines_t           lines_nx, lines_r;
  logic             busy_r, done_r;

  btn_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .en   (state != IDLE),
    .limit(limit),
    .tc   (tc)
  );

  // Next-state, bit/code bookkeeping and line decode from the next state.
  always_comb begin
    state_nx = state;
    bit_nx   = bit_idx;
    code_nx  = code;
    post_nx  = post_abort;
    done_nx  = 1'b0;
    limit    = (state inside {BIT_PRESS, START_PRESS, ABORT_PRESS}) ? PRESS_LIM : GAP_LIM;

    if (bus.abort) begin
      // Abort outranks everything, including a simultaneous in_valid in IDLE,
      // and restarts an abort sequence already under way.
      state_nx = ABORT_GAP;
      post_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state_nx = BIT_PRESS;
            bit_nx   = '0;
            code_nx  = bus.in_code;
          end
        end
        BIT_PRESS:   if (tc) state_nx = BIT_GAP;
        BIT_GAP: begin
          if (tc) begin
            if (bit_idx == 3'd7) begin
              state_nx = START_PRESS;
            end else begin
              state_nx = BIT_PRESS;
              bit_nx   = bit_idx + 3'd1;
            end
          end
        end
        START_PRESS: if (tc) state_nx = START_GAP;
        START_GAP: begin
          if (tc) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        ABORT_PRESS: begin
          if (tc) begin
            state_nx = ABORT_GAP;
            post_nx  = 1'b1;
          end
        end
        ABORT_GAP: begin
          // The same state serves as both the pre-press and the closing gap.
          if (tc) begin
            if (post_abort) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end else begin
              state_nx = ABORT_PRESS;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    load     = bus.abort || (state_nx != state);
    lines_nx = lines_for(state_nx, code_nx[bit_nx]);
  end

  // State, bookkeeping and registered output lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      code       <= '0;
      post_abort <= 1'b0;
      lines_r    <= '1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_idx    <= bit_nx;
      code       <= code_nx;
      post_abort <= post_nx;
      lines_r    <= lines_nx;
      busy_r     <= (state_nx != IDLE);
      done_r     <= done_nx;
    end
  end

  assign bus.one_n       = lines_r.one_n;
  assign bus.zero_n      = lines_r.zero_n;
  assign bus.start_n     = lines_r.start_n;
  assign bus.reset_btn_n = lines_r.reset_btn_n;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  // Gated by the live abort so a same-cycle abort blocks acceptance.
  assign bus.in_ready    = !busy_r && !bus.abort;

endmodule

// File: tb/tb_button_seq_driver.sv
// Self-checking bench for button_seq_driver with scaled press/gap timing.
module tb_button_seq_driver;
  localparam int unsigned P  = 4;
  localparam int unsigned G  = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned DB_DEPTH = 3;

  logic clk = 1'b0;
  logic reset;

  button_seq_driver_if bus();

  button_seq_driver #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .CNT_W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic one_n;
    logic zero_n;
    logic start_n;
    logic rst_n;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam obs_t GAP_OBS  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam obs_t DONE_OBS = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [7:0]  code;
    string       seq;
    int unsigned lat;
  } vec_t;

  obs_t        expq[$];
  byte         press_log[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned low_run = 0;
  logic        prev_low = 1'b0;
  logic        prev_cut = 1'b0;
  logic [3:0]  prev_lines = 4'hF;
  int unsigned last_done_cyc = 0;
  int unsigned accept_cyc = 0;
  logic        done_seen = 1'b0;

  int unsigned db_low [4];
  int unsigned db_idx = 0;
  logic [7:0]  db_shift = '0;
  logic [3:0]  db_row = '0;
  logic [3:0]  db_col = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_log(string name, string exp);
    string a;
    a = "";
    foreach (press_log[i]) a = $sformatf("%s%c", a, press_log[i]);
    tests++;
    if (a != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, a, exp);
    end
  endtask

  task automatic push_n(obs_t o, int unsigned n);
    for (int unsigned i = 0; i < n; i++) expq.push_back(o);
  endtask

  // Whole keyed sequence for one accepted code, cycle by cycle from T+1.
  task automatic push_code(logic [7:0] c);
    obs_t o;
    for (int unsigned k = 0; k < 8; k++) begin
      o = GAP_OBS;
      if (c[k]) o.one_n = 1'b0;
      else      o.zero_n = 1'b0;
      push_n(o, P);
      push_n(GAP_OBS, G);
    end
    o = GAP_OBS;
    o.start_n = 1'b0;
    push_n(o, P);
    push_n(GAP_OBS, G);
    expq.push_back(DONE_OBS);
  endtask

  task automatic push_abort();
    obs_t o;
    push_n(GAP_OBS, G);
    o = GAP_OBS;
    o.rst_n = 1'b0;
    push_n(o, P);
    push_n(GAP_OBS, G);
    expq.push_back(DONE_OBS);
  endtask

  task automatic db_event(int unsigned line);
    case (line)
      3, 2: begin
        if (db_idx < 8) begin
          db_shift[db_idx[2:0]] = (line == 3);
          db_idx++;
        end
      end
      1: begin
        if (db_idx == 8) begin
          db_col = db_shift[3:0];
          db_row = db_shift[7:4];
        end
        db_idx = 0;
      end
      default: db_idx = 0;
    endcase
  endtask

  // One clock cycle: compare this cycle's outputs, then advance the model
  // with the inputs the DUT samples at the coming edge.
  task automatic step();
    obs_t       e;
    logic [3:0] lines;
    logic       low_now;
    int unsigned nlow;
    #1;
    e = (expq.size() > 0) ? expq.pop_front() : IDLE_OBS;
    lines = {bus.one_n, bus.zero_n, bus.start_n, bus.reset_btn_n};
    check("outputs", 32'({lines, bus.busy, bus.done, bus.in_ready}),
          32'({e, (!e.busy && !bus.abort)}));

    nlow = 0;
    for (int unsigned i = 0; i < 4; i++) if (!lines[i]) nlow++;
    check("single_low", 32'(nlow > 1), 32'(0));

    low_now = (lines != 4'hF);
    if (prev_low && !low_now && !prev_cut) check("pulse_len", low_run, P);
    low_run = low_now ? (prev_low ? low_run + 1 : 1) : 0;

    for (int unsigned i = 0; i < 4; i++) begin
      if (prev_lines[i] && !lines[i]) begin
        case (i)
          3: press_log.push_back("1");
          2: press_log.push_back("0");
          1: press_log.push_back("S");
          default: press_log.push_back("R");
        endcase
      end
      if (!lines[i]) begin
        db_low[i]++;
        if (db_low[i] == DB_DEPTH) db_event(i);
      end else begin
        db_low[i] = 0;
      end
    end
    prev_lines = lines;
    prev_low   = low_now;
    if (bus.done) begin
      done_seen     = 1'b1;
      last_done_cyc = cyc;
    end

    prev_cut = 1'b0;
    if (reset) begin
      expq.delete();
      prev_cut = 1'b1;
    end else if (bus.abort) begin
      expq.delete();
      push_abort();
      prev_cut = 1'b1;
    end else if (!e.busy && bus.in_valid) begin
      push_code(bus.in_code);
      accept_cyc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(string name, int unsigned max);
    done_seen = 1'b0;
    for (int unsigned n = 0; n < max; n++) begin
      step();
      if (done_seen) break;
    end
    check(name, 32'(done_seen), 32'(1));
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc;
    for (int i = 0; i < 4; i++) db_low[i] = 0;
    vecs[0] = '{8'hA5, "10100101S", 109};
    vecs[1] = '{8'h00, "00000000S", 109};
    vecs[2] = '{8'hFF, "11111111S", 109};
    vecs[3] = '{8'h0F, "11110000S", 109};
    vecs[4] = '{8'h3C, "00111100S", 109};
    vecs[5] = '{8'h81, "10000001S", 109};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.abort    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_lines", 32'({bus.one_n, bus.zero_n, bus.start_n, bus.reset_btn_n}), 32'hF);
    check("rst_ctrl", 32'({bus.in_ready, bus.busy, bus.done}), 32'b100);
    @(negedge clk);
    step();

    // Table of full code transfers
    for (int v = 0; v < 6; v++) begin
      press_log.delete();
      db_idx = 0;
      bus.in_valid = 1'b1;
      bus.in_code  = vecs[v].code;
      step();
      bus.in_valid = 1'b0;
      bus.in_code  = 8'($urandom);
      run_until_done("code_done", 200);
      check("code_latency", last_done_cyc - accept_cyc, vecs[v].lat);
      check_log("code_seq", vecs[v].seq);
      if (v == 0) begin
        check("db_row", 32'(db_row), 32'hA);
        check("db_col", 32'(db_col), 32'h5);
      end
    end

    // Abort at T+30 of a transfer
    bus.in_valid = 1'b1;
    bus.in_code  = 8'hC6;
    step();
    bus.in_valid = 1'b0;
    repeat (29) step();
    bus.abort = 1'b1;
    begin
      int unsigned abort_cyc;
      abort_cyc = cyc;
      step();
      bus.abort = 1'b0;
      press_log.delete();
      run_until_done("abort_done", 100);
      check("abort_latency", last_done_cyc - abort_cyc, 2 * G + P + 1);
    end
    repeat (5) step();
    check_log("abort_seq", "R");

    // Abort and in_valid together in IDLE; held in_valid accepted at done
    press_log.delete();
    accept_cyc = 0;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    bus.in_code  = 8'h3C;
    step();
    bus.abort = 1'b0;
    run_until_done("abort_valid_done", 100);
    check("late_accept_cyc", accept_cyc, last_done_cyc);
    bus.in_valid = 1'b0;
    run_until_done("late_code_done", 200);
    check_log("abort_then_code", "R00111100S");

    // Reset during bit 3 press
    press_log.delete();
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    repeat (37) step();
    check("in_bit3_press", 32'(bus.one_n), 32'(0));
    check_log("pre_reset_seq", "0101");
    press_log.delete();
    done_seen = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    check("no_done_after_reset", 32'(done_seen), 32'(0));
    check_log("quiet_after_reset", "");
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h0F;
    step();
    bus.in_valid = 1'b0;
    run_until_done("post_reset_done", 200);
    check("post_reset_latency", last_done_cyc - accept_cyc, 109);
    check_log("post_reset_seq", "11110000S");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rc = 8'($urandom);
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_code  = rc;
      bus.abort    = ($urandom_range(0, 299) == 0);
      reset        = ($urandom_range(0, 999) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    reset        = 1'b0;
    repeat (250) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
